// File: rtl/pulse_delay_line.sv
// rtl/pulse_delay_line.sv - per-channel event detector with fixed-latency delay line and pulse stretcher
//
// Purpose:
//   Detects a selectable event (level-high, rising, falling or both edges) on each
//   of BITS independent input lines. It delays each event through a DEPTH-stage
//   pipeline and then stretches it into an output pulse STRETCH cycles wide. The
//   pipeline and the stretchers only advance on cycles with en_i high.
//
// Parameters:
//   BITS     number of independent channels (>=1)
//   DEPTH    delay-line stages, in enabled cycles (>=1)
//   STRETCH  output pulse width, in enabled cycles (>=1)
//   MODE     0=level-high, 1=rising, 2=falling, 3=both edges
//
// Ports:
//   clk_i    system clock, all state on posedge
//   rst_i    synchronous reset, active high (highest priority)
//   en_i     pipeline advance enable; low freezes delay line and stretchers
//   flush_i  synchronous clear of in-flight events; edge history keeps tracking
//   in_i     raw event lines, already synchronous to clk_i
//   out_o    delayed, stretched event pulses (decoded from registered state)
//   valid_o  high once DEPTH enabled cycles have elapsed since reset/flush

module pulse_delay_line #(
    parameter int BITS    = 8,
    parameter int DEPTH   = 4,
    parameter int STRETCH = 1,
    parameter int MODE    = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            flush_i,
    input  logic [BITS-1:0] in_i,
    output logic [BITS-1:0] out_o,
    output logic            valid_o
);

    localparam int CW = $clog2(STRETCH + 1);
    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);

    // Edge history: previous sample of every input line.
    logic [BITS-1:0] in_q;
    logic [BITS-1:0] in_d;

    // Delay line; stage DEPTH-1 is the tail that feeds the stretchers.
    logic [BITS-1:0] dl_q [DEPTH];
    logic [BITS-1:0] dl_d [DEPTH];

    // Per-channel stretch down-counters.
    logic [CW-1:0]   cnt_q [BITS];
    logic [CW-1:0]   cnt_d [BITS];

    // Enabled cycles since reset/flush, saturating at DEPTH.
    logic [FW-1:0]   fill_q;
    logic [FW-1:0]   fill_d;

    logic [BITS-1:0] ev_w;
    logic [BITS-1:0] tail_w;

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    always_comb begin
        if (MODE == 0) begin
            ev_w = in_i;
        end else if (MODE == 1) begin
            ev_w = in_i & ~in_q;
        end else if (MODE == 2) begin
            ev_w = ~in_i & in_q;
        end else begin
            ev_w = in_i ^ in_q;
        end
    end

    // The history register tracks the input on every cycle, including
    // disabled and flushed ones, so releasing flush or en never manufactures
    // an edge out of a level that was already present.
    always_comb begin
        in_d = in_i;
    end

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    always_comb begin
        dl_d = dl_q;
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_d[k] = '0;
            end
        end else if (en_i) begin
            // Events arriving while en_i is low are dropped on purpose.
            dl_d[0] = ev_w;
            for (int k = 1; k < DEPTH; k++) begin
                dl_d[k] = dl_q[k-1];
            end
        end
    end

    assign tail_w = dl_q[DEPTH-1];

    // ------------------------------------------------------------------
    // Stretchers
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < BITS; i++) begin
            if (flush_i) begin
                cnt_d[i] = '0;
            end else if (en_i) begin
                // A retrigger reloads rather than adds, so closely spaced
                // events merge into one pulse ending STRETCH after the last.
                if (tail_w[i]) begin
                    cnt_d[i] = CNT_LOAD;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill tracking
    // ------------------------------------------------------------------
    always_comb begin
        fill_d = fill_q;
        if (flush_i) begin
            fill_d = '0;
        end else if (en_i && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q   <= '0;
            fill_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dl_q[k] <= '0;
            end
            for (int i = 0; i < BITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            in_q   <= in_d;
            fill_q <= fill_d;
            for (int k = 0; k < DEPTH; k++) begin
                dl_q[k] <= dl_d[k];
            end
            for (int i = 0; i < BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded purely from registers
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < BITS; i++) begin
            out_o[i] = (cnt_q[i] != '0);
        end
    end

    assign valid_o = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_pulse_delay_line.sv
// tb/tb_pulse_delay_line.sv - scoreboard bench for pulse_delay_line over several MODE/STRETCH builds

module tb_pulse_delay_line;

    localparam int DEPTH = 4;
    localparam int NI    = 5;

    // Instance k: 0 rising/S1, 1 both/S1, 2 rising/S3, 3 level/S2, 4 falling/S1
    int mode_k [NI] = '{1, 3, 1, 0, 2};
    int str_k  [NI] = '{1, 1, 3, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout [NI];
    logic       dval [NI];

    always #5 clk = ~clk;

    pulse_delay_line #(.BITS(8), .DEPTH(DEPTH), .STRETCH(1), .MODE(1)) u_r (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .in_i(din),
        .out_o(dout[0]), .valid_o(dval[0]));
    pulse_delay_line #(.BITS(8), .DEPTH(DEPTH), .STRETCH(1), .MODE(3)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .in_i(din),
        .out_o(dout[1]), .valid_o(dval[1]));
    pulse_delay_line #(.BITS(8), .DEPTH(DEPTH), .STRETCH(3), .MODE(1)) u_s (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .in_i(din),
        .out_o(dout[2]), .valid_o(dval[2]));
    pulse_delay_line #(.BITS(8), .DEPTH(DEPTH), .STRETCH(2), .MODE(0)) u_l (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .in_i(din),
        .out_o(dout[3]), .valid_o(dval[3]));
    pulse_delay_line #(.BITS(8), .DEPTH(DEPTH), .STRETCH(1), .MODE(2)) u_f (
        .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .in_i(din),
        .out_o(dout[4]), .valid_o(dval[4]));

    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;

    // Reference model: events indexed by enabled-edge number; an event at
    // index n is visible after enabled edges n+DEPTH .. n+DEPTH+S-1, unless a
    // reset/flush mark lies at or after n.
    int         t_idx = 0;
    int         mark = 0;
    logic [7:0] m_inq = '0;
    logic [7:0] hist [NI][256];
    logic [8:0] sb_q [$];

    function automatic logic [7:0] mev(int mode, logic [7:0] cur, logic [7:0] prev);
        case (mode)
            0:       return cur;
            1:       return cur & ~prev;
            2:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    function automatic logic [7:0] mout(int k);
        logic [7:0] r;
        r = '0;
        for (int n = t_idx - DEPTH - str_k[k] + 1; n <= t_idx - DEPTH; n++) begin
            if (n > mark) r |= hist[k][n % 256];
        end
        return r;
    endfunction

    task automatic step(input logic r, input logic f, input logic e, input logic [7:0] d);
        logic [8:0] want;
        logic [8:0] got;
        rst = r; flush = f; en = e; din = d;
        if (r) begin
            m_inq = '0;
            mark  = t_idx;
        end else begin
            if (!f && e) begin
                t_idx++;
                for (int k = 0; k < NI; k++) hist[k][t_idx % 256] = mev(mode_k[k], d, m_inq);
            end
            if (f) mark = t_idx;
            m_inq = d;
        end
        for (int k = 0; k < NI; k++) sb_q.push_back({((t_idx - mark) >= DEPTH), mout(k)});
        @(posedge clk);
        #1;
        step_no++;
        for (int k = 0; k < NI; k++) begin
            want = sb_q.pop_front();
            got  = {dval[k], dout[k]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sb inst%0d step%0d: got valid=%b out=%h, want valid=%b out=%h",
                         k, step_no, got[8], got[7:0], want[8], want[7:0]);
            end
        end
    endtask

    task automatic drain();
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({dval[k], dout[k]} !== 9'h000) begin
                miscompares++;
                $display("FAIL reset inst%0d: got valid=%b out=%h, want 0/00", k, dval[k], dout[k]);
            end
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            vectors++;
            if (dval[0] !== (i >= DEPTH)) begin
                miscompares++;
                $display("FAIL fill_valid i=%0d: got %b want %b", i, dval[0], (i >= DEPTH));
            end
        end
    endtask

    task automatic test_rising_single();
        drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h01);
            vectors++;
            if (dout[0][0] !== (i == 4)) begin
                miscompares++;
                $display("FAIL rise_single i=%0d: got %b want %b", i, dout[0][0], (i == 4));
            end
        end
    endtask

    task automatic test_both_edges();
        drain();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, (i < 3) ? 8'h08 : 8'h00);
            vectors++;
            if (dout[1] !== (((i == 4) || (i == 7)) ? 8'h08 : 8'h00)) begin
                miscompares++;
                $display("FAIL both_edges i=%0d: got %h", i, dout[1]);
            end
            vectors++;
            if (dout[4][3] !== (i == 7)) begin
                miscompares++;
                $display("FAIL falling i=%0d: got %b want %b", i, dout[4][3], (i == 7));
            end
        end
    endtask

    task automatic test_stretch_merge();
        drain();
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 1) ? 8'h00 : 8'h02);
            vectors++;
            if (dout[2][1] !== ((i >= 4) && (i <= 8))) begin
                miscompares++;
                $display("FAIL stretch_merge i=%0d: got %b want %b", i, dout[2][1], ((i >= 4) && (i <= 8)));
            end
        end
    endtask

    task automatic test_enable_gap();
        logic [7:0] d;
        drain();
        for (int i = 0; i < 12; i++) begin
            d = 8'h10 | ((i >= 2) ? 8'h20 : 8'h00);
            step(1'b0, 1'b0, !((i >= 1) && (i <= 3)), d);
            vectors++;
            if (dout[0][5:4] !== {1'b0, (i == 7)}) begin
                miscompares++;
                $display("FAIL en_gap i=%0d: got %b want %b", i, dout[0][5:4], {1'b0, (i == 7)});
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] d;
        logic       vexp;
        drain();
        for (int i = 0; i < 11; i++) begin
            d = (i == 0) ? 8'h40 : 8'hC0;
            step(1'b0, (i == 2), 1'b1, d);
            vexp = (i < 2) || (i >= 6);
            vectors++;
            if ({dval[0], dout[0], dout[1]} !== {vexp, 16'h0000}) begin
                miscompares++;
                $display("FAIL flush i=%0d: got valid=%b out=%h/%h want valid=%b out=00/00",
                         i, dval[0], dout[0], dout[1], vexp);
            end
        end
    endtask

    task automatic test_reset_held();
        drain();
        for (int i = 0; i < 10; i++) begin
            step((i < 2), 1'b0, 1'b1, 8'h04);
            if (i < 2) begin
                for (int k = 0; k < NI; k++) begin
                    vectors++;
                    if ({dval[k], dout[k]} !== 9'h000) begin
                        miscompares++;
                        $display("FAIL rst_held inst%0d i=%0d: got valid=%b out=%h", k, i, dval[k], dout[k]);
                    end
                end
            end else begin
                vectors++;
                if ({dval[0], dout[0][2]} !== {(i >= 5), (i == 6)}) begin
                    miscompares++;
                    $display("FAIL rst_release i=%0d: got %b%b want %b%b",
                             i, dval[0], dout[0][2], (i >= 5), (i == 6));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 400; i++) begin
            d = d ^ ($urandom & $urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0), d);
        end
    endtask

    initial begin
        test_reset();
        test_rising_single();
        test_both_edges();
        test_stretch_merge();
        test_enable_gap();
        test_flush();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
